// File: rtl/fns_pkg.sv
// rtl/fns_pkg.sv - shared Fibonacci weights, range limit, mode and FSM types
package fns_pkg;

    typedef enum logic {
        FNS_GREEDY = 1'b0,
        FNS_IFNS   = 1'b1
    } fns_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fns_state_e;

    // F(0)=0, F(1)=F(2)=1, ...; used only at elaboration to build weight tables
    function automatic logic [31:0] fib(input int k);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [31:0] FNS_MAX(input int n);
        return fib(n + 2) - 32'd1;
    endfunction

endpackage

// File: rtl/fns_digit_slice.sv
// rtl/fns_digit_slice.sv - one combinational FNS digit decision and remainder update
module fns_digit_slice
    import fns_pkg::*;
#(
    parameter int RW = 12
) (
    input  logic [RW-1:0] r,
    input  logic          p,
    input  fns_mode_e     mode,
    input  logic [31:0]   fk,
    input  logic [31:0]   fk1,
    output logic          d,
    output logic [RW-1:0] r_next
);
    logic [31:0] r_ext;

    assign r_ext = 32'(r);

    // In the tie band F(k) <= r < F(k+1) IFNS repeats the previous digit
    always_comb begin
        if (r_ext >= fk1) begin
            d = 1'b1;
        end else if (r_ext < fk) begin
            d = 1'b0;
        end else begin
            d = (mode == FNS_IFNS) ? p : 1'b1;
        end
        r_next = d ? (r - fk[RW-1:0]) : r;
    end

endmodule

// File: rtl/fns_cac_encoder_iter.sv
// rtl/fns_cac_encoder_iter.sv - iterative FNS/IFNS crosstalk-avoidance encoder, MSB digit first
module fns_cac_encoder_iter
    import fns_pkg::*;
#(
    parameter int DATA_W         = 11,
    parameter int CODE_W         = 16,
    parameter int DIGITS_PER_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_err
);
    localparam int RW = DATA_W + 1;
    localparam int KW = $clog2(CODE_W + 2);
    localparam int NT = 2 ** KW;
    localparam logic [31:0] LIMIT = FNS_MAX(CODE_W);

    if ((CODE_W % DIGITS_PER_CYC) != 0) begin : g_bad_chunk
        $error("CODE_W must be a multiple of DIGITS_PER_CYC");
    end

    fns_state_e                state;
    fns_mode_e                 mode_q;
    logic [RW-1:0]             r_q;
    logic                      p_q;
    logic [KW-1:0]             idx_q;
    logic [CODE_W-1:0]         code_q;
    logic                      err_q;
    logic                      load;
    logic                      in_big;
    logic [31:0]               fib_tab [NT];
    logic [RW-1:0]             r_ch [DIGITS_PER_CYC+1];
    logic                      p_ch [DIGITS_PER_CYC+1];
    logic [DIGITS_PER_CYC-1:0] chunk;
    logic [CODE_W-1:0]         code_next;

    for (genvar i = 0; i < NT; i++) begin : g_fib
        assign fib_tab[i] = (i <= CODE_W + 1) ? fib(i) : 32'd0;
    end

    assign r_ch[0] = r_q;
    assign p_ch[0] = p_q;

    // Slice j resolves digit k = idx - j; at k = 1 the weights F(1)=F(2)=1 make d_1 = r
    for (genvar j = 0; j < DIGITS_PER_CYC; j++) begin : g_slice
        logic [KW-1:0] k;
        assign k = idx_q - KW'(j);
        fns_digit_slice #(.RW(RW)) u_slice (
            .r      (r_ch[j]),
            .p      (p_ch[j]),
            .mode   (mode_q),
            .fk     (fib_tab[k]),
            .fk1    (fib_tab[k + KW'(1)]),
            .d      (chunk[DIGITS_PER_CYC-1-j]),
            .r_next (r_ch[j+1])
        );
        assign p_ch[j+1] = chunk[DIGITS_PER_CYC-1-j];
    end

    assign code_next = code_q | (CODE_W'(chunk) << (idx_q - KW'(DIGITS_PER_CYC)));
    assign in_big    = 32'(in_data) > LIMIT;
    assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    assign load      = in_valid & in_ready;
    assign out_valid = (state == ST_DONE);
    assign out_code  = code_q;
    assign out_err   = err_q;

    // Out-of-range words run with a zero remainder, so every digit resolves to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= FNS_GREEDY;
            r_q    <= '0;
            p_q    <= 1'b0;
            idx_q  <= '0;
            code_q <= '0;
            err_q  <= 1'b0;
        end else if (load) begin
            state  <= ST_RUN;
            mode_q <= fns_mode_e'(in_mode);
            r_q    <= in_big ? '0 : RW'(in_data);
            p_q    <= 1'b0;
            idx_q  <= KW'(CODE_W);
            code_q <= '0;
            err_q  <= in_big;
        end else begin
            case (state)
                ST_RUN: begin
                    code_q <= code_next;
                    r_q    <= r_ch[DIGITS_PER_CYC];
                    p_q    <= p_ch[DIGITS_PER_CYC];
                    idx_q  <= idx_q - KW'(DIGITS_PER_CYC);
                    if (idx_q == KW'(DIGITS_PER_CYC)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fns_cac_encoder_iter.sv
// tb/tb_fns_cac_encoder_iter.sv - directed and sampled checks of the FNS encoder
module tb_fns_cac_encoder_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = 12'd0;
    logic        in_mode = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_code;
    logic        out_err;
    logic        ready12;
    logic        valid12;
    logic [15:0] code12;
    logic        err12;
    logic [10:0] in_data11;

    int n_cmp = 0;
    int n_bad = 0;

    assign in_data11 = in_data[10:0];

    always #5 clk = ~clk;

    fns_cac_encoder_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data11),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err)
    );

    fns_cac_encoder_iter #(.DATA_W(12)) dut12 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (ready12),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (valid12),
        .out_ready (out_ready),
        .out_code  (code12),
        .out_err   (err12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int fibv(input int k);
        int a;
        int b;
        int t;
        a = 0;
        b = 1;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [15:0] ref_code(input int v, input bit ifns);
        int r;
        bit p;
        bit d;
        logic [15:0] c;
        r = v;
        p = 1'b0;
        c = 16'd0;
        for (int k = 16; k >= 2; k--) begin
            if (r >= fibv(k + 1)) d = 1'b1;
            else if (r < fibv(k)) d = 1'b0;
            else d = ifns ? p : 1'b1;
            if (d) r = r - fibv(k);
            c[k-1] = d;
            p = d;
        end
        c[0] = (r != 0);
        return c;
    endfunction

    function automatic int code_sum(input logic [15:0] c);
        int s;
        s = 0;
        for (int k = 1; k <= 16; k++) if (c[k-1]) s = s + fibv(k);
        return s;
    endfunction

    function automatic bit ftx_ok(input logic [15:0] c);
        bit a;
        bit b;
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (c[i+:3] == 3'b010) a = 1'b1;
            if (c[i+:3] == 3'b101) b = 1'b1;
        end
        return !(a && b);
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic xfer(input logic [11:0] data, input logic mode,
                        output logic [15:0] c11, output logic e11,
                        output logic [15:0] c12, output logic e12, output int lat);
        @(negedge clk);
        in_data  = data;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        c11 = out_code;
        e11 = out_err;
        c12 = code12;
        e12 = err12;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] c;
        logic [15:0] c2;
        logic        e;
        logic        e2;
        int          lat;
        int          v;
        logic        m;
        logic [15:0] exp_c;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        xfer(12'd1, 1'b1, c, e, c2, e2, lat);
        check("ifns1_code", 32'(c), 32'h0001);
        check("ifns1_err", 32'(e), 32'd0);
        check("ifns1_lat", 32'(lat), 32'd4);
        xfer(12'd1, 1'b0, c, e, c2, e2, lat);
        check("greedy1_code", 32'(c), 32'h0002);
        xfer(12'd4, 1'b1, c, e, c2, e2, lat);
        check("ifns4_code", 32'(c), 32'h0007);
        xfer(12'd4, 1'b0, c, e, c2, e2, lat);
        check("greedy4_code", 32'(c), 32'h000A);
        xfer(12'd0, 1'b1, c, e, c2, e2, lat);
        check("ifns0_code", 32'(c), 32'h0000);
        xfer(12'd0, 1'b0, c, e, c2, e2, lat);
        check("greedy0_code", 32'(c), 32'h0000);

        xfer(12'd2583, 1'b1, c, e, c2, e2, lat);
        check("max_code", 32'(c2), 32'hFFFF);
        check("max_err", 32'(e2), 32'd0);
        xfer(12'd2584, 1'b1, c, e, c2, e2, lat);
        check("over_code", 32'(c2), 32'h0000);
        check("over_err", 32'(e2), 32'd1);
        check("over_lat", 32'(lat), 32'd4);

        // Stall in DONE, then release with a new word waiting
        @(negedge clk);
        in_data  = 12'd100;
        in_mode  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("stall_lat", 32'(lat), 32'd4);
        exp_c = ref_code(100, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_code", 32'(out_code), 32'(exp_c));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 12'd4;
        in_mode   = 1'b0;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_valid_drop", 32'(out_valid), 32'd0);
        wait_valid(lat);
        check("b2b_lat", 32'(lat), 32'd4);
        check("b2b_code", 32'(out_code), 32'h000A);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during the second RUN cycle
        @(negedge clk);
        in_data  = 12'd2047;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_code", 32'(out_code), 32'd0);
        check("midrst_err", 32'(out_err), 32'd0);
        xfer(12'd4, 1'b1, c, e, c2, e2, lat);
        check("postrst_code", 32'(c), 32'h0007);
        check("postrst_lat", 32'(lat), 32'd4);

        for (int i = 0; i < 60; i++) begin
            v = $urandom_range(2047, 0);
            m = (i % 2) == 1;
            xfer(12'(v), m, c, e, c2, e2, lat);
            check("sweep_ref", 32'(c), 32'(ref_code(v, m)));
            check("sweep_sum", 32'(code_sum(c)), 32'(v));
            check("sweep_12w", 32'(c2), 32'(c));
            if (m) check("sweep_ftx", 32'(ftx_ok(c)), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
